// File: rtl/info_banner_ctrl.sv
// Slide-in / hold / slide-out controller for an on-screen info banner.
// Tracks the banner top row per frame and reports pixel hits with bitmap offsets.
module info_banner_ctrl #(
    parameter int OBJECT_WIDTH_X  = 300,
    parameter int OBJECT_HEIGHT_Y = 100,
    parameter int TARGET_X        = 20,
    parameter int TARGET_Y        = 10,
    parameter int START_Y         = -100,
    parameter int SLIDE_STEP      = 10,
    parameter int HOLD_FRAMES     = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        showReq,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLIDE_IN  = 2'd1,
        HOLD      = 2'd2,
        SLIDE_OUT = 2'd3
    } state_t;

    localparam logic signed [11:0] X_LO     = 12'(TARGET_X);
    localparam logic signed [11:0] X_HI     = 12'(TARGET_X + OBJECT_WIDTH_X);
    localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] TGT_Y    = 12'(TARGET_Y);
    localparam logic signed [11:0] STRT_Y   = 12'(START_Y);
    localparam logic signed [11:0] STEP_S   = 12'(SLIDE_STEP);
    localparam logic        [7:0]  HOLD_END = 8'(HOLD_FRAMES - 1);

    state_t             state_q;
    logic signed [11:0] topLeftY_q;
    logic        [7:0]  frameCnt_q;
    logic               inside_q;
    logic        [10:0] offX_q;
    logic        [10:0] offY_q;

    logic signed [11:0] pxS;
    logic signed [11:0] pyS;
    logic signed [11:0] yHi;
    logic signed [11:0] diffX;
    logic signed [11:0] diffY;
    logic signed [11:0] stepUp;
    logic signed [11:0] stepDn;
    logic signed [11:0] slideInY;
    logic signed [11:0] slideOutY;
    logic               insideNow;

    // Pixel coordinates are zero-extended, so rows above the screen never match.
    always_comb begin
        pxS       = $signed({1'b0, pixelX});
        pyS       = $signed({1'b0, pixelY});
        yHi       = topLeftY_q + HEIGHT_S;
        diffX     = pxS - X_LO;
        diffY     = pyS - topLeftY_q;
        insideNow = (state_q != IDLE) &&
                    (pxS >= X_LO) && (pxS < X_HI) &&
                    (pyS >= topLeftY_q) && (pyS < yHi);
        stepUp    = topLeftY_q + STEP_S;
        stepDn    = topLeftY_q - STEP_S;
        slideInY  = (stepUp >= TGT_Y)  ? TGT_Y  : stepUp;
        slideOutY = (stepDn <= STRT_Y) ? STRT_Y : stepDn;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            topLeftY_q <= STRT_Y;
            frameCnt_q <= '0;
            inside_q   <= 1'b0;
            offX_q     <= '0;
            offY_q     <= '0;
        end else begin
            inside_q <= insideNow;
            offX_q   <= insideNow ? diffX[10:0] : '0;
            offY_q   <= insideNow ? diffY[10:0] : '0;

            case (state_q)
                IDLE: begin
                    if (showReq) begin
                        state_q <= SLIDE_IN;
                    end
                end
                SLIDE_IN: begin
                    if (startOfFrame) begin
                        topLeftY_q <= slideInY;
                        if (slideInY == TGT_Y) begin
                            state_q    <= HOLD;
                            frameCnt_q <= '0;
                        end
                    end
                end
                HOLD: begin
                    // A fresh request restarts the hold, even on the exit frame.
                    if (showReq) begin
                        frameCnt_q <= '0;
                    end else if (startOfFrame) begin
                        if (frameCnt_q == HOLD_END) begin
                            state_q    <= SLIDE_OUT;
                            frameCnt_q <= '0;
                        end else begin
                            frameCnt_q <= frameCnt_q + 8'd1;
                        end
                    end
                end
                SLIDE_OUT: begin
                    if (showReq) begin
                        state_q <= SLIDE_IN;
                    end else if (startOfFrame) begin
                        topLeftY_q <= slideOutY;
                        if (slideOutY == STRT_Y) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = offX_q;
    assign offsetY         = offY_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_info_banner_ctrl.sv
// Directed bench for info_banner_ctrl: slide timing, hit window, hold restart, reset abort.
module tb_info_banner_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        showReq;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    info_banner_ctrl #(
        .OBJECT_WIDTH_X (300),
        .OBJECT_HEIGHT_Y(100),
        .TARGET_X       (20),
        .TARGET_Y       (10),
        .START_Y        (-100),
        .SLIDE_STEP     (10),
        .HOLD_FRAMES    (3)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .showReq        (showReq),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .InsideRectangle(InsideRectangle),
        .busy           (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input logic req);
        startOfFrame = 1'b1;
        showReq      = req;
        tick();
        startOfFrame = 1'b0;
        showReq      = 1'b0;
    endtask

    task automatic do_req;
        showReq = 1'b1;
        tick();
        showReq = 1'b0;
    endtask

    task automatic drive_pixel(input int px, input int py);
        pixelX = 11'(px);
        pixelY = 11'(py);
        tick();
    endtask

    // Row used to observe the banner top: first visible row of the banner, or row 0.
    function automatic int probe_row(input int top);
        return (top < 0) ? 0 : top;
    endfunction

    task automatic test_reset;
        resetN       = 1'b0;
        startOfFrame = 1'b1;
        showReq      = 1'b1;
        pixelX       = 11'd20;
        pixelY       = 11'd10;
        tick();
        tick();
        n_cmp++;
        if (InsideRectangle !== 1'b0) begin n_bad++; $display("FAIL reset inside: got %b want 0", InsideRectangle); end
        n_cmp++;
        if (offsetX !== 11'd0 || offsetY !== 11'd0) begin
            n_bad++; $display("FAIL reset offsets: got (%0d,%0d) want (0,0)", offsetX, offsetY);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        startOfFrame = 1'b0;
        showReq      = 1'b0;
        resetN       = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL post-reset idle busy: got %b want 0", busy); end
    endtask

    task automatic test_slide_in;
        int py;
        int et;
        logic ei;
        // Request coincides with a frame pulse: the top row must not move yet.
        do_frame(1'b1);
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) do_frame(1'b0);
            et = -100 + 10 * k;
            py = probe_row(et);
            drive_pixel(27, py);
            ei = (py < et + 100);
            n_cmp++;
            if (InsideRectangle !== ei) begin
                n_bad++; $display("FAIL slide_in f%0d inside: got %b want %b", k, InsideRectangle, ei);
            end
            n_cmp++;
            if (offsetY !== (ei ? 11'(py - et) : 11'd0)) begin
                n_bad++; $display("FAIL slide_in f%0d offsetY: got %0d want %0d", k, offsetY, ei ? py - et : 0);
            end
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL slide_in f%0d busy: got %b want 1", k, busy); end
        end
    endtask

    task automatic test_window;
        int vx[6]  = '{20, 319, 320, 19, 20, 20};
        int vy[6]  = '{10, 109, 109, 50, 110, 9};
        logic vi[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int ox[6]  = '{0, 299, 0, 0, 0, 0};
        int oy[6]  = '{0, 99, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive_pixel(vx[i], vy[i]);
            n_cmp++;
            if (InsideRectangle !== vi[i]) begin
                n_bad++; $display("FAIL window (%0d,%0d) inside: got %b want %b", vx[i], vy[i], InsideRectangle, vi[i]);
            end
            n_cmp++;
            if (offsetX !== 11'(ox[i]) || offsetY !== 11'(oy[i])) begin
                n_bad++; $display("FAIL window (%0d,%0d) offsets: got (%0d,%0d) want (%0d,%0d)",
                                  vx[i], vy[i], offsetX, offsetY, ox[i], oy[i]);
            end
        end
    endtask

    task automatic test_hold_exit;
        int py;
        int et;
        logic eb;
        logic ei;
        for (int k = 1; k <= 14; k++) begin
            do_frame(1'b0);
            et = (k <= 3) ? 10 : 10 - 10 * (k - 3);
            eb = (k < 14);
            py = probe_row(et);
            drive_pixel(27, py);
            ei = eb && (py < et + 100);
            n_cmp++;
            if (InsideRectangle !== ei) begin
                n_bad++; $display("FAIL hold_exit f%0d inside: got %b want %b", k, InsideRectangle, ei);
            end
            n_cmp++;
            if (offsetY !== (ei ? 11'(py - et) : 11'd0)) begin
                n_bad++; $display("FAIL hold_exit f%0d offsetY: got %0d want %0d", k, offsetY, ei ? py - et : 0);
            end
            n_cmp++;
            if (busy !== eb) begin n_bad++; $display("FAIL hold_exit f%0d busy: got %b want %b", k, busy, eb); end
        end
    endtask

    task automatic test_hold_restart;
        int et;
        do_req();
        for (int k = 0; k < 11; k++) do_frame(1'b0);
        do_frame(1'b0);
        do_frame(1'b0);
        // Frames after the request: c (with request), d, e, f keep top at 10; g starts the exit.
        for (int k = 0; k < 5; k++) begin
            do_frame(k == 0);
            et = (k < 4) ? 10 : 0;
            drive_pixel(27, et);
            n_cmp++;
            if (InsideRectangle !== 1'b1 || offsetY !== 11'd0) begin
                n_bad++; $display("FAIL hold_restart step%0d: got inside=%b offY=%0d want inside=1 offY=0 (top %0d)",
                                  k, InsideRectangle, offsetY, et);
            end
        end
    endtask

    task automatic test_reslide;
        int tops[7] = '{-10, -20, -30, -40, -40, -30, -20};
        int et;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) do_req();
            else if (k == 5) do_frame(1'b1);
            else do_frame(1'b0);
            et = tops[k];
            drive_pixel(27, 0);
            n_cmp++;
            if (InsideRectangle !== 1'b1 || offsetY !== 11'(-et)) begin
                n_bad++; $display("FAIL reslide step%0d: got inside=%b offY=%0d want inside=1 offY=%0d",
                                  k, InsideRectangle, offsetY, -et);
            end
        end
        for (int k = 0; k < 3; k++) do_frame(1'b0);
        drive_pixel(27, 10);
        n_cmp++;
        if (InsideRectangle !== 1'b1 || offsetY !== 11'd0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL reslide hold: got inside=%b offY=%0d busy=%b want 1/0/1",
                              InsideRectangle, offsetY, busy);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 14; k++) do_frame(1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid idle busy: got %b want 0", busy); end
        do_req();
        for (int k = 0; k < 5; k++) do_frame(1'b0);
        drive_pixel(20, 0);
        n_cmp++;
        if (InsideRectangle !== 1'b1 || offsetX !== 11'd0 || offsetY !== 11'd50) begin
            n_bad++; $display("FAIL reset_mid pre: got inside=%b off=(%0d,%0d) want 1 (0,50)",
                              InsideRectangle, offsetX, offsetY);
        end
        resetN = 1'b0;
        #1;
        n_cmp++;
        if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid async: got inside=%b off=(%0d,%0d) busy=%b want all 0",
                              InsideRectangle, offsetX, offsetY, busy);
        end
        startOfFrame = 1'b1;
        showReq      = 1'b1;
        tick();
        startOfFrame = 1'b0;
        showReq      = 1'b0;
        resetN       = 1'b1;
        drive_pixel(27, 0);
        n_cmp++;
        if (InsideRectangle !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid after release: got inside=%b busy=%b want 0/0", InsideRectangle, busy);
        end
        do_frame(1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid no pending req: got busy=%b want 0", busy); end
        do_req();
        do_frame(1'b0);
        drive_pixel(27, 0);
        n_cmp++;
        if (InsideRectangle !== 1'b1 || offsetY !== 11'd90 || busy !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid restart: got inside=%b offY=%0d busy=%b want 1/90/1",
                              InsideRectangle, offsetY, busy);
        end
    endtask

    initial begin
        startOfFrame = 1'b0;
        showReq      = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        resetN       = 1'b0;
        test_reset();
        test_slide_in();
        test_window();
        test_hold_exit();
        test_hold_restart();
        test_reslide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
